acc_pixmap: RTL and testbench

Parametrised successor to the task-0 inversion accelerator. It streams a rectangular image of WORDS 32-bit words from SRC_BASE, applies a per-pixel operation to the four byte-lanes, and writes each result word to DST_BASE.
- Supported operations: invert, threshold, copy, saturating brighten.
- Sits between the top-level start/finish control and the shared single-port word memory.
- Used in place of acc0.

---
 rtl/acc_pkg.sv | 30 +++
 rtl/acc_pix_op.sv | 34 +++
 rtl/acc_pixmap.sv | 117 +++++++++++
 tb/tb_acc_pixmap.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// ============================================================================
// acc_pkg : shared types and image constants for the pixel-map accelerator
// Rev 1.0
// ============================================================================
`default_nettype none

package acc_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      MODE_INV = 2'd0,
      MODE_THR = 2'd1,
      MODE_CPY = 2'd2,
      MODE_BRT = 2'd3
   } mode_t;

   localparam int IMG_W     = 352;
   localparam int IMG_H     = 288;
   localparam int IMG_WORDS = 25344;

endpackage

`default_nettype wire

// File: rtl/acc_pix_op.sv
// ============================================================================
// acc_pix_op : combinational per-pixel operation on one 8-bit byte lane
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_pix_op
   import acc_pkg::*;
(
   input  logic [7:0] p,
   input  mode_t      m,
   input  logic [7:0] param,
   output logic [7:0] q
);

   logic [8:0] w_sum;

   // Brighten is summed in 9 bits so the carry drives saturation.
   assign w_sum = {1'b0, p} + {1'b0, param};

   always_comb begin
      q = p;
      case (m)
         MODE_INV: q = 8'hFF - p;
         MODE_THR: q = (p >= param) ? 8'hFF : 8'h00;
         MODE_CPY: q = p;
         MODE_BRT: q = w_sum[8] ? 8'hFF : w_sum[7:0];
         default:  q = p;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/acc_pixmap.sv
// ============================================================================
// acc_pixmap : streams WORDS words from SRC_BASE through a 4-lane pixel op to
// DST_BASE, three cycles per word. Optional ACC_CYCLE_CNT_EN adds `cycles`.
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_pixmap
   import acc_pkg::*;
#(
   parameter int WORDS    = IMG_WORDS,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = IMG_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] addr,
   input  logic [31:0] dataR,
   output logic [31:0] dataW,
   output logic        en,
   output logic        we,
   input  logic        start,
   output logic        finish,
   input  logic [1:0]  mode,
   input  logic [7:0]  param
`ifdef ACC_CYCLE_CNT_EN
   ,
   output logic [31:0] cycles
`endif
);

   localparam logic [15:0] C_SRC  = 16'(SRC_BASE);
   localparam logic [15:0] C_DST  = 16'(DST_BASE);
   localparam logic [15:0] C_LAST = 16'(WORDS - 1);

   state_t      r_state;
   logic [15:0] r_idx;
   mode_t       r_mode;
   logic [7:0]  r_param;
   logic [31:0] w_result;

   generate
      for (genvar g = 0; g < 4; g++) begin : g_lane
         acc_pix_op u_op (
            .p     (dataR[8*g +: 8]),
            .m     (r_mode),
            .param (r_param),
            .q     (w_result[8*g +: 8])
         );
      end
   endgenerate

   // addr is preloaded on entry to RD/WR so it is valid during the request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= 16'd0;
         r_mode  <= MODE_INV;
         r_param <= 8'd0;
         addr    <= 16'd0;
         dataW   <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mode  <= mode_t'(mode);
                  r_param <= param;
                  r_idx   <= 16'd0;
                  addr    <= C_SRC;
                  r_state <= RD;
               end
            end
            RD: r_state <= CAP;
            CAP: begin
               dataW   <= w_result;
               addr    <= C_DST + r_idx;
               r_state <= WR;
            end
            WR: begin
               if (r_idx == C_LAST) begin
                  r_state <= DONE;
               end else begin
                  r_idx   <= r_idx + 16'd1;
                  addr    <= C_SRC + r_idx + 16'd1;
                  r_state <= RD;
               end
            end
            DONE: begin
               if (!start) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign en     = (r_state == RD) || (r_state == WR);
   assign we     = (r_state == WR);
   assign finish = (r_state == DONE);

`ifdef ACC_CYCLE_CNT_EN
   logic w_busy;
   assign w_busy = (r_state == RD) || (r_state == CAP) || (r_state == WR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycles <= 32'd0;
      end else if (r_state == IDLE && start) begin
         cycles <= 32'd0;
      end else if (w_busy && cycles != 32'hFFFF_FFFF) begin
         cycles <= cycles + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_acc_pixmap.sv
// ============================================================================
// tb_acc_pixmap : self-checking bench for acc_pixmap with a small image
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_acc_pixmap;

   localparam int W   = 4;
   localparam int SRC = 16;
   localparam int DST = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addr;
   logic [31:0] dataR = 32'd0;
   logic [31:0] dataW;
   logic        en, we, finish;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [7:0]  param = 8'd0;
`ifdef ACC_CYCLE_CNT_EN
   logic [31:0] cycles;
`endif

   acc_pixmap #(.WORDS(W), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .dataR  (dataR),
      .dataW  (dataW),
      .en     (en),
      .we     (we),
      .start  (start),
      .finish (finish),
      .mode   (mode),
      .param  (param)
`ifdef ACC_CYCLE_CNT_EN
      ,
      .cycles (cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      logic [1:0]  md;
      logic [7:0]  pr;
      logic [31:0] src;
      logic [31:0] exp;
   } vec_t;

   logic [31:0] mem [0:255];
   wr_t         sb_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] w,
                                         input logic [1:0] md, input logic [7:0] pr);
      logic [31:0] r;
      int          s;
      r = 32'd0;
      for (int k = 0; k < 4; k++) begin
         s = int'(w[8*k +: 8]);
         case (md)
            2'd0: s = 255 - s;
            2'd1: s = (s >= int'(pr)) ? 255 : 0;
            2'd2: s = s;
            default: s = (s + int'(pr) > 255) ? 255 : s + int'(pr);
         endcase
         r[8*k +: 8] = 8'(s);
      end
      return r;
   endfunction

   // Single-port synchronous memory model.
   always @(posedge clk) begin
      if (en && !we) dataR <= mem[addr[7:0]];
      if (en && we)  mem[addr[7:0]] <= dataW;
   end

   // Scoreboard: every write must match the next expected write.
   always @(negedge clk) begin
      wr_t e;
      if (!reset && en && we) begin
         if (sb_q.size() == 0) begin
            check(1'b0, "stray_write", {16'd0, addr}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check(addr == e.a, "write_addr", {16'd0, addr}, {16'd0, e.a});
            check(dataW == e.d, "write_data", dataW, e.d);
         end
      end
   end

   task automatic push_job(input logic [1:0] md, input logic [7:0] pr);
      for (int j = 0; j < W; j++) begin
         wr_t e;
         e.a = 16'(DST + j);
         e.d = model(mem[SRC + j], md, pr);
         sb_q.push_back(e);
      end
   endtask

   task automatic run_job(input logic [1:0] md, input logic [7:0] pr,
                          input bit change_mid, input int hold);
      int cnt;
      bit got;
      push_job(md, pr);
      @(negedge clk);
      mode = md; param = pr; start = 1'b1;
      cnt = 0; got = 1'b0;
      while (cnt < 200 && !got) begin
         @(posedge clk); cnt++; #1;
         if (finish) got = 1'b1;
         if (change_mid && cnt == 2) begin mode = ~md; param = ~pr; end
      end
      check(got && cnt == 3*W + 1, "finish_latency", 32'(cnt), 32'(3*W + 1));
      check(sb_q.size() == 0, "writes_pending", 32'(sb_q.size()), 32'd0);
`ifdef ACC_CYCLE_CNT_EN
      check(cycles == 32'(3*W), "cycles_at_finish", cycles, 32'(3*W));
`endif
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check(finish == 1'b1, "finish_held", {31'd0, finish}, 32'd1);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check(finish == 1'b0 && en == 1'b0, "drop_to_idle", {30'd0, finish, en}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [6];
      int   cnt;
      vecs[0] = '{2'd0, 8'h00, 32'h00FF7F01, 32'hFF0080FE};
      vecs[1] = '{2'd1, 8'h80, 32'h7F80FF00, 32'h00FFFF00};
      vecs[2] = '{2'd1, 8'h80, 32'h807F7F80, 32'hFF0000FF};
      vecs[3] = '{2'd3, 8'h10, 32'hF0EF0010, 32'hFFFF1020};
      vecs[4] = '{2'd2, 8'h55, 32'hA5C30F96, 32'hA5C30F96};
      vecs[5] = '{2'd3, 8'hFF, 32'h00010203, 32'hFFFFFFFF};

      for (int a = 0; a < 256; a++) mem[a] = $urandom;

      repeat (2) @(posedge clk);
      #1;
      check(addr == 16'd0 && dataW == 32'd0, "reset_addr_data", {16'd0, addr} | dataW, 32'd0);
      check({en, we, finish} == 3'b000, "reset_ctrl", {29'd0, en, we, finish}, 32'd0);
`ifdef ACC_CYCLE_CNT_EN
      check(cycles == 32'd0, "reset_cycles", cycles, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      for (int v = 0; v < 6; v++) begin
         mem[SRC] = vecs[v].src;
         for (int j = 1; j < W; j++) mem[SRC + j] = $urandom;
         run_job(vecs[v].md, vecs[v].pr, 1'b0, 0);
         check(mem[DST] == vecs[v].exp, "vector_word", mem[DST], vecs[v].exp);
      end

      // Mode/param change mid-job is ignored; start held past finish does not retrigger.
      for (int j = 0; j < W; j++) mem[SRC + j] = $urandom;
      run_job(2'd0, 8'h20, 1'b1, 10);

      // Asynchronous reset during CAP of word 2, then a full restart.
      for (int j = 0; j < W; j++) begin
         mem[SRC + j] = $urandom;
         mem[DST + j] = 32'hDEADBEEF;
      end
      push_job(2'd0, 8'h00);
      @(negedge clk);
      mode = 2'd0; param = 8'h00; start = 1'b1;
      cnt = 0;
      while (cnt < 8) begin @(posedge clk); cnt++; end
      #1;
      reset = 1'b1;
      start = 1'b0;
      #1;
      check({en, we, finish} == 3'b000, "async_reset_ctrl", {29'd0, en, we, finish}, 32'd0);
`ifdef ACC_CYCLE_CNT_EN
      check(cycles == 32'd0, "async_reset_cycles", cycles, 32'd0);
`endif
      check(sb_q.size() == W - 2, "writes_before_reset", 32'(sb_q.size()), 32'(W - 2));
      sb_q.delete();
      @(negedge clk);
      reset = 1'b0;
      run_job(2'd0, 8'h00, 1'b0, 0);
      for (int j = 0; j < W; j++)
         check(mem[DST + j] == model(mem[SRC + j], 2'd0, 8'h00), "rewrite_after_reset",
               mem[DST + j], model(mem[SRC + j], 2'd0, 8'h00));

      // Random images through every mode.
      for (int m = 0; m < 4; m++) begin
         for (int j = 0; j < W; j++) mem[SRC + j] = $urandom;
         run_job(2'(m), 8'($urandom_range(0, 255)), 1'b0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
